pe_tile_feeder: RTL and testbench

- Drives the operand side of one 16-lane bit-serial PE tile.
- Loads 16 weight bytes into the tile's weight register file through a serial write port.
- Encodes 16 unsigned 8-bit activations per vector into the per-lane bit_enable and partial_product_select words the tile consumes.
- Tracks the tile's fixed pipeline latency so a result_valid strobe lines up with the tile's result output. Sits between the activation/weight buffers and the tile.

---
 rtl/pe_tile_pkg.sv | 31 +++
 rtl/pe_tile_feeder_if.sv | 27 ++
 rtl/act_digit_encoder.sv | 19 +
 rtl/pe_tile_feeder.sv | 157 +++++++++++++++
 tb/tb_pe_tile_feeder.sv | 238 +++++++++++++++++++++++
 5 files changed

// File: rtl/pe_tile_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_tile_pkg : shared constants, state type and digit-enable helper |
// | Revision    : 1.0                                                  |
// +--------------------------------------------------------------------+
package pe_tile_pkg;

  localparam int LANES   = 16;
  localparam int DIGITS  = 4;
  localparam int DIGIT_W = 2;
  localparam int ACT_W   = 8;
  localparam int W_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_W  = 2'd1,
    DRAIN_W = 2'd2,
    STREAM  = 2'd3
  } feeder_state_t;

  // A digit contributes work to the tile only when it is non-zero.
  function automatic logic [DIGITS-1:0] digit_enable(input logic [ACT_W-1:0] act);
    logic [DIGITS-1:0] en;
    for (int j = 0; j < DIGITS; j++) begin
      en[j] = |act[DIGIT_W*j +: DIGIT_W];
    end
    return en;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pe_tile_feeder_if.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_tile_feeder_if : weight and activation handshakes into feeder   |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
interface pe_tile_feeder_if;
  import pe_tile_pkg::*;

  logic                   w_valid;
  logic                   w_ready;
  logic [ACT_W-1:0]       w_data;
  logic                   act_valid;
  logic                   act_ready;
  logic [LANES*ACT_W-1:0] act_vec;

  modport master (
    output w_valid, w_data, act_valid, act_vec,
    input  w_ready, act_ready
  );

  modport slave (
    input  w_valid, w_data, act_valid, act_vec,
    output w_ready, act_ready
  );

endinterface
`default_nettype wire

// File: rtl/act_digit_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | act_digit_encoder : one activation byte -> digit enables / codes   |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
module act_digit_encoder
  import pe_tile_pkg::*;
(
  input  logic [ACT_W-1:0]          act,
  output logic [DIGITS-1:0]         bit_enable,
  output logic [DIGITS*DIGIT_W-1:0] pps
);

  // Digit codes are the radix-4 digits of the byte, d3 in the top bits.
  assign pps        = act;
  assign bit_enable = digit_enable(act);

endmodule
`default_nettype wire

// File: rtl/pe_tile_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | pe_tile_feeder : weight loader, activation digit encoder and       |
// |                  result-valid tracker for one 16-lane PE tile.     |
// | Optional       : PE_FEED_STATS_EN adds vector / zero-digit counters|
// | Revision       : 1.0                                               |
// +--------------------------------------------------------------------+
module pe_tile_feeder #(
  parameter int TILE_LAT = 5,
  parameter int LANES    = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  pe_tile_feeder_if.slave        feed,
  output logic                   weight_wen,
  output logic [pe_tile_pkg::ACT_W-1:0] weight_din,
  output logic [pe_tile_pkg::DIGITS-1:0] bit_enable [0:LANES-1],
  output logic [pe_tile_pkg::DIGITS*pe_tile_pkg::DIGIT_W-1:0] partial_product_select [0:LANES-1],
  output logic                   result_valid,
  output logic                   busy
`ifdef PE_FEED_STATS_EN
  ,
  output logic [31:0]            stat_vectors,
  output logic [31:0]            stat_zero_digits
`endif
);
  import pe_tile_pkg::*;

  localparam int                CNT_W     = $clog2(W_BYTES);
  localparam logic [CNT_W-1:0]  LAST_BYTE = CNT_W'(W_BYTES - 1);

  feeder_state_t state, state_next;

  logic [CNT_W-1:0]               byte_cnt;
  logic [TILE_LAT:0]              issued_sr;
  logic                           w_hs;
  logic                           act_hs;
  logic [DIGITS-1:0]              enc_be  [0:LANES-1];
  logic [DIGITS*DIGIT_W-1:0]      enc_pps [0:LANES-1];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    act_digit_encoder u_enc (
      .act        (feed.act_vec[ACT_W*i +: ACT_W]),
      .bit_enable (enc_be[i]),
      .pps        (enc_pps[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next     = state;
    feed.w_ready   = 1'b0;
    feed.act_ready = 1'b0;
    case (state)
      IDLE: begin
        feed.w_ready   = 1'b1;
        // A pending weight byte takes priority over a pending vector.
        feed.act_ready = ~feed.w_valid;
        if (feed.w_valid) begin
          state_next = LOAD_W;
        end else if (feed.act_valid) begin
          state_next = STREAM;
        end
      end
      LOAD_W: begin
        feed.w_ready = 1'b1;
        if (feed.w_valid && byte_cnt == LAST_BYTE) begin
          state_next = DRAIN_W;
        end
      end
      DRAIN_W: begin
        state_next = IDLE;
      end
      STREAM: begin
        feed.act_ready = 1'b1;
        if (!feed.act_valid && feed.w_valid) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
    if (rst) begin
      feed.w_ready   = 1'b0;
      feed.act_ready = 1'b0;
    end
  end

  assign w_hs   = feed.w_valid   & feed.w_ready;
  assign act_hs = feed.act_valid & feed.act_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt   <= '0;
      weight_wen <= 1'b0;
      weight_din <= '0;
      issued_sr  <= '0;
      for (int i = 0; i < LANES; i++) begin
        bit_enable[i]             <= '0;
        partial_product_select[i] <= '0;
      end
    end else begin
      weight_wen <= w_hs;
      if (w_hs) begin
        weight_din <= feed.w_data;
        byte_cnt   <= byte_cnt + CNT_W'(1);
      end
      issued_sr <= {issued_sr[TILE_LAT-1:0], act_hs};
      // Cycles without a handshake present an all-zero bubble to the tile.
      for (int i = 0; i < LANES; i++) begin
        bit_enable[i]             <= act_hs ? enc_be[i]  : '0;
        partial_product_select[i] <= act_hs ? enc_pps[i] : '0;
      end
    end
  end

  assign result_valid = issued_sr[TILE_LAT];
  assign busy         = (state != IDLE) | (|issued_sr);

`ifdef PE_FEED_STATS_EN
  logic [6:0]  zero_digits;
  logic [32:0] zero_sum;

  always_comb begin
    zero_digits = '0;
    for (int i = 0; i < LANES; i++) begin
      for (int j = 0; j < DIGITS; j++) begin
        zero_digits = zero_digits + {6'd0, ~enc_be[i][j]};
      end
    end
  end

  assign zero_sum = {1'b0, stat_zero_digits} + {26'd0, zero_digits};

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_vectors     <= '0;
      stat_zero_digits <= '0;
    end else if (act_hs) begin
      if (~&stat_vectors) begin
        stat_vectors <= stat_vectors + 32'd1;
      end
      stat_zero_digits <= zero_sum[32] ? '1 : zero_sum[31:0];
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_pe_tile_feeder.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_pe_tile_feeder : directed + randomized bench with a cycle-level |
// |                     reference model of the feeder's visible rules  |
// | Revision          : 1.0                                            |
// +--------------------------------------------------------------------+
module tb_pe_tile_feeder;

  localparam int TILE_LAT = 5;
  localparam int RES_LAT  = TILE_LAT + 1;

  logic       clk = 1'b0;
  logic       rst;
  logic       weight_wen;
  logic [7:0] weight_din;
  logic [3:0] bit_enable [0:15];
  logic [7:0] partial_product_select [0:15];
  logic       result_valid;
  logic       busy;

  pe_tile_feeder_if feed_if ();

  pe_tile_feeder #(
    .TILE_LAT (TILE_LAT),
    .LANES    (16)
  ) dut (
    .clk                    (clk),
    .rst                    (rst),
    .feed                   (feed_if),
    .weight_wen             (weight_wen),
    .weight_din             (weight_din),
    .bit_enable             (bit_enable),
    .partial_product_select (partial_product_select),
    .result_valid           (result_valid),
    .busy                   (busy)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  bit   exp_rv [int];
  logic pre_w_ready;
  logic pre_act_ready;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected digit enables: a radix-4 digit is active when it is non-zero.
  function automatic logic [63:0] model_be(input logic [127:0] vec);
    logic [63:0] r;
    int a;
    for (int i = 0; i < 16; i++) begin
      a = int'(vec[8*i +: 8]);
      for (int j = 0; j < 4; j++) begin
        r[4*i+j] = ((a / (4 ** j)) % 4) != 0;
      end
    end
    return r;
  endfunction

  function automatic logic [63:0] pack_be();
    logic [63:0] r;
    for (int i = 0; i < 16; i++) r[4*i +: 4] = bit_enable[i];
    return r;
  endfunction

  function automatic logic [127:0] pack_pps();
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = partial_product_select[i];
    return r;
  endfunction

  function automatic logic [127:0] rand_vec();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // One clock cycle: drive inputs, note readies, then check what the
  // previous cycle's accepts should have produced.
  task automatic tick(input bit wv, input logic [7:0] wd, input bit wacc,
                      input bit av, input logic [127:0] vec, input bit aacc);
    feed_if.w_valid   = wv;
    feed_if.w_data    = wd;
    feed_if.act_valid = av;
    feed_if.act_vec   = vec;
    #1;
    pre_w_ready   = feed_if.w_ready;
    pre_act_ready = feed_if.act_ready;
    if (aacc) exp_rv[cyc + RES_LAT] = 1'b1;
    @(negedge clk);
    cyc++;
    check("weight_wen", weight_wen, wacc);
    if (wacc) check("weight_din", weight_din, wd);
    check("bit_enable", pack_be(), aacc ? model_be(vec) : 64'd0);
    check("pps", pack_pps(), aacc ? vec : 128'd0);
    check("result_valid", result_valid, exp_rv.exists(cyc) ? 1 : 0);
  endtask

  initial begin
    logic [127:0] vec;
    logic [127:0] vec_c;
    int           sent;
    int           pulses;
    int           base;
    int           rel;
    bit           wv;
    bit           av;

    rst               = 1'b1;
    feed_if.w_valid   = 1'b0;
    feed_if.w_data    = '0;
    feed_if.act_valid = 1'b0;
    feed_if.act_vec   = '0;
    repeat (3) @(negedge clk);
    check("rst_weight_wen", weight_wen, 0);
    check("rst_weight_din", weight_din, 0);
    check("rst_bit_enable", pack_be(), 0);
    check("rst_pps", pack_pps(), 0);
    check("rst_result_valid", result_valid, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    #1;
    check("idle_w_ready", feed_if.w_ready, 1);
    check("idle_act_ready", feed_if.act_ready, 1);

    // Contiguous weight load 0x01..0x10.
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 8'(i + 1), 1'b1, 1'b0, '0, 1'b0);
      check("load_w_ready", pre_w_ready, 1);
    end
    tick(1'b0, 8'd0, 1'b0, 1'b0, '0, 1'b0);
    check("drain_w_ready", pre_w_ready, 0);
    #1;
    check("load_done_w_ready", feed_if.w_ready, 1);
    check("load_done_busy", busy, 0);

    // Weight load with w_valid toggling every other cycle.
    sent   = 0;
    pulses = 0;
    for (int k = 0; sent < 16; k++) begin
      wv = (k % 2) == 0;
      tick(wv, 8'($urandom), wv, 1'b0, '0, 1'b0);
      if (weight_wen === 1'b1) pulses++;
      if (wv) sent++;
    end
    tick(1'b0, 8'd0, 1'b0, 1'b0, '0, 1'b0);
    check("gap_drain_w_ready", pre_w_ready, 0);
    check("gap_pulse_count", pulses, 16);
    #1;
    check("gap_done_w_ready", feed_if.w_ready, 1);

    // Directed encoding vector.
    vec            = rand_vec();
    vec[7:0]       = 8'hE4;
    vec[15:8]      = 8'h00;
    vec[127:120]   = 8'hFF;
    tick(1'b0, 8'd0, 1'b0, 1'b1, vec, 1'b1);
    check("enc_act_ready", pre_act_ready, 1);
    check("enc_be_lane0", bit_enable[0], 4'b1110);
    check("enc_be_lane1", bit_enable[1], 4'b0000);
    check("enc_be_lane15", bit_enable[15], 4'b1111);
    check("enc_pps_lane0", partial_product_select[0], 8'hE4);
    check("enc_pps_lane1", partial_product_select[1], 8'h00);
    check("enc_pps_lane15", partial_product_select[15], 8'hFF);
    tick(1'b0, 8'd0, 1'b0, 1'b0, '0, 1'b0);

    // Randomized streaming with bubbles, then drain.
    repeat (24) begin
      av  = $urandom_range(0, 3) != 0;
      vec = rand_vec();
      tick(1'b0, 8'd0, 1'b0, av, vec, av);
    end
    repeat (RES_LAT + 1) tick(1'b0, 8'd0, 1'b0, 1'b0, '0, 1'b0);

    // Latency: vectors at relative cycles 0,1,2,5; leave STREAM at 6.
    base = cyc;
    for (int k = 0; k < 13; k++) begin
      av = (k == 0) || (k == 1) || (k == 2) || (k == 5);
      wv = (k == 6);
      tick(wv, 8'd0, 1'b0, av, rand_vec(), av);
      rel = cyc - base;
      check("lat_result_valid", result_valid, (rel == 6) || (rel == 7) || (rel == 8) || (rel == 11));
      check("lat_busy", busy, rel <= 11);
    end

    // Contention: weight wins in IDLE, vector waits until after DRAIN_W.
    vec_c = rand_vec();
    tick(1'b1, 8'hA0, 1'b1, 1'b1, vec_c, 1'b0);
    check("cont_act_ready", pre_act_ready, 0);
    check("cont_w_ready", pre_w_ready, 1);
    for (int i = 1; i < 16; i++) begin
      tick(1'b1, 8'(8'hA0 + i), 1'b1, 1'b1, vec_c, 1'b0);
    end
    tick(1'b0, 8'd0, 1'b0, 1'b1, vec_c, 1'b0);
    check("cont_drain_act_ready", pre_act_ready, 0);
    tick(1'b0, 8'd0, 1'b0, 1'b1, vec_c, 1'b1);
    check("cont_idle_act_ready", pre_act_ready, 1);
    tick(1'b1, 8'd0, 1'b0, 1'b0, '0, 1'b0);
    repeat (RES_LAT) tick(1'b0, 8'd0, 1'b0, 1'b0, '0, 1'b0);
    check("cont_busy", busy, 0);

    // Reset after 7 bytes, then a fresh full load.
    for (int i = 0; i < 7; i++) begin
      tick(1'b1, 8'($urandom_range(1, 255)), 1'b1, 1'b0, '0, 1'b0);
    end
    rst             = 1'b1;
    feed_if.w_valid = 1'b0;
    @(negedge clk);
    cyc++;
    exp_rv.delete();
    check("mid_rst_weight_wen", weight_wen, 0);
    check("mid_rst_weight_din", weight_din, 0);
    check("mid_rst_bit_enable", pack_be(), 0);
    check("mid_rst_pps", pack_pps(), 0);
    check("mid_rst_result_valid", result_valid, 0);
    check("mid_rst_busy", busy, 0);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) begin
      tick(1'b1, 8'(8'h30 + i), 1'b1, 1'b0, '0, 1'b0);
    end
    tick(1'b0, 8'd0, 1'b0, 1'b0, '0, 1'b0);
    check("reload_drain_w_ready", pre_w_ready, 0);
    #1;
    check("reload_done_w_ready", feed_if.w_ready, 1);
    check("reload_done_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
